// File: rtl/line_buffer_sequencer.sv
// Frame controller for a shift-register line buffer: gates the shift enable and tracks input/output raster coordinates.
// Latency: EN and flush_sel are combinational with the pixel; out_valid and the status pulses are registered one cycle later.
// Backpressure: none; pix_valid gaps stall all counters, and a flush runs for exactly NUMBER_OF_LINES*WIDTH cycles.
module line_buffer_sequencer #(
    parameter int WIDTH           = 640,
    parameter int HEIGHT          = 480,
    parameter int NUMBER_OF_LINES = 3,
    parameter int XW              = 10,
    parameter int YW              = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pix_valid,
    input  logic          sof,
    output logic          EN,
    output logic          flush_sel,
    output logic [XW-1:0] x_in,
    output logic [YW-1:0] y_in,
    output logic          out_valid,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic          busy,
    output logic          frame_done,
    output logic          err_sync
);

    // D is the buffer depth in shifts; a full frame is PIXELS input shifts plus D flush shifts.
    localparam int D      = NUMBER_OF_LINES * WIDTH;
    localparam int PIXELS = WIDTH * HEIGHT;
    localparam int NW     = $clog2(D + PIXELS + 1);
    localparam int FW     = $clog2(D + 1);

    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [NW-1:0] N_FIRST = NW'(D);
    localparam logic [NW-1:0] N_END   = NW'(D + PIXELS);
    localparam logic [FW-1:0] F_LAST  = FW'(D - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [XW-1:0] x_in_nxt;
    logic [YW-1:0] y_in_nxt;
    logic [FW-1:0] flush_cnt;
    logic [FW-1:0] flush_cnt_nxt;
    logic [NW-1:0] shift_cnt;      // shifts since the current frame started
    logic [NW-1:0] shift_cnt_nxt;
    logic          restart;
    logic          shift;
    logic          out_valid_nxt;
    logic          done_nxt;
    logic          err_nxt;

    // A sof only counts when it rides on a real pixel; it always opens a fresh frame.
    assign restart = pix_valid & sof;
    assign EN      = shift;
    assign busy    = (state != IDLE);

    // Next-state, input-side counters, and the shift enable for this cycle.
    always_comb begin
        state_nxt     = state;
        x_in_nxt      = x_in;
        y_in_nxt      = y_in;
        flush_cnt_nxt = flush_cnt;
        shift_cnt_nxt = shift_cnt;
        shift         = 1'b0;
        flush_sel     = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        if (restart) begin
            // The sof pixel itself is (0,0) and is shifted in, so the next input is column 1.
            shift         = 1'b1;
            state_nxt     = RUN;
            x_in_nxt      = XW'(1);
            y_in_nxt      = '0;
            flush_cnt_nxt = '0;
            shift_cnt_nxt = NW'(1);
            err_nxt       = (state != IDLE);
        end else begin
            case (state)
                RUN: begin
                    if (pix_valid) begin
                        shift         = 1'b1;
                        shift_cnt_nxt = shift_cnt + NW'(1);
                        if (x_in == X_LAST) begin
                            x_in_nxt = '0;
                            if (y_in == Y_LAST) begin
                                y_in_nxt  = '0;
                                state_nxt = FLUSH;
                            end else begin
                                y_in_nxt = y_in + YW'(1);
                            end
                        end else begin
                            x_in_nxt = x_in + XW'(1);
                        end
                    end
                end
                FLUSH: begin
                    shift         = 1'b1;
                    flush_sel     = 1'b1;
                    shift_cnt_nxt = shift_cnt + NW'(1);
                    if (flush_cnt == F_LAST) begin
                        flush_cnt_nxt = '0;
                        shift_cnt_nxt = '0;
                        state_nxt     = IDLE;
                        done_nxt      = 1'b1;
                    end else begin
                        flush_cnt_nxt = flush_cnt + FW'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        // Reset wins over any pixel arriving in the same cycle.
        if (reset) begin
            shift     = 1'b0;
            flush_sel = 1'b0;
        end
    end

    // After shift n the buffer head holds pixel n-D; only n in [D, D+PIXELS) is a real pixel.
    // The final flush shift clears shift_cnt_nxt, which keeps it outside that window.
    always_comb begin
        out_valid_nxt = shift && (shift_cnt_nxt >= N_FIRST) && (shift_cnt_nxt < N_END);
    end

    // State, input-side counters and status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            x_in       <= '0;
            y_in       <= '0;
            flush_cnt  <= '0;
            shift_cnt  <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            err_sync   <= 1'b0;
        end else begin
            state      <= state_nxt;
            x_in       <= x_in_nxt;
            y_in       <= y_in_nxt;
            flush_cnt  <= flush_cnt_nxt;
            shift_cnt  <= shift_cnt_nxt;
            out_valid  <= out_valid_nxt;
            frame_done <= done_nxt;
            err_sync   <= err_nxt;
        end
    end

    // Output raster position: advances once per valid output pixel, wraps to (0,0) after the last one.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_out <= '0;
            y_out <= '0;
        end else if (restart) begin
            x_out <= '0;
            y_out <= '0;
        end else if (out_valid) begin
            if (x_out == X_LAST) begin
                x_out <= '0;
                y_out <= (y_out == Y_LAST) ? '0 : y_out + YW'(1);
            end else begin
                x_out <= x_out + XW'(1);
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_sequencer.sv
// Directed bench for line_buffer_sequencer at WIDTH=4, HEIGHT=3, two lines (D=8).
// A frame-level model predicts every output each cycle; literal per-scenario totals pin the model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_line_buffer_sequencer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NL = 2;
    localparam int D  = NL * W;
    localparam int WH = W * H;

    logic       clock;
    logic       reset;
    logic       pix_valid;
    logic       sof;
    logic       EN;
    logic       flush_sel;
    logic [1:0] x_in;
    logic [1:0] y_in;
    logic       out_valid;
    logic [1:0] x_out;
    logic [1:0] y_out;
    logic       busy;
    logic       frame_done;
    logic       err_sync;

    line_buffer_sequencer #(
        .WIDTH(W), .HEIGHT(H), .NUMBER_OF_LINES(NL), .XW(2), .YW(2)
    ) dut (
        .clock(clock), .reset(reset), .pix_valid(pix_valid), .sof(sof),
        .EN(EN), .flush_sel(flush_sel), .x_in(x_in), .y_in(y_in),
        .out_valid(out_valid), .x_out(x_out), .y_out(y_out),
        .busy(busy), .frame_done(frame_done), .err_sync(err_sync)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: phase (0 idle, 1 receiving, 2 flushing), pixels received,
    // flush shifts done, total shifts since frame start, and the registered flags.
    int ms = 0, mp = 0, mf = 0, mn = 0;
    bit mov = 0, mdone = 0, merr = 0;
    bit m_restart, m_shift;

    always @(posedge clock) begin
        if (reset) begin
            ms = 0; mp = 0; mf = 0; mn = 0;
            mov = 0; mdone = 0; merr = 0;
        end else begin
            m_restart = pix_valid && sof;
            m_shift   = (ms == 0) ? m_restart : ((ms == 1) ? pix_valid : 1'b1);
            mdone = 0;
            merr  = 0;
            if (m_restart) begin
                merr = (ms != 0);
                ms = 1; mp = 1; mf = 0; mn = 1;
            end else if (ms == 1 && pix_valid) begin
                mp++; mn++;
                if (mp == WH) begin ms = 2; mp = 0; end
            end else if (ms == 2) begin
                mf++; mn++;
                if (mf == D) begin ms = 0; mf = 0; mdone = 1; end
            end
            mov = m_shift && (mn >= D) && (mn < D + WH);
            if (ms == 0) mn = 0;
        end
    end

    // Observation totals used by the literal per-scenario checks.
    bit chk_on = 0;
    int cyc = 0;
    int en_cnt = 0, fs_cnt = 0, ov_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
    int first_ov = -1, done_cyc = -1;
    int base_cyc = 0;
    bit last_en, last_fs;
    int e_en, e_fs;

    always @(negedge clock) begin
        if (chk_on) begin
            if (reset)        e_en = 0;
            else if (ms == 0) e_en = int'(pix_valid && sof);
            else if (ms == 1) e_en = int'(pix_valid);
            else              e_en = 1;
            e_fs = int'(!reset && ms == 2 && !(pix_valid && sof));
            check("EN", int'(EN), e_en);
            check("flush_sel", int'(flush_sel), e_fs);
            check("x_in", int'(x_in), mp % W);
            check("y_in", int'(y_in), mp / W);
            check("out_valid", int'(out_valid), int'(mov));
            check("busy", int'(busy), int'(ms != 0));
            check("frame_done", int'(frame_done), int'(mdone));
            check("err_sync", int'(err_sync), int'(merr));
            if (mov) begin
                check("x_out", int'(x_out), (mn - D) % W);
                check("y_out", int'(y_out), (mn - D) / W);
            end else if (ms == 0) begin
                check("x_out_idle", int'(x_out), 0);
                check("y_out_idle", int'(y_out), 0);
            end
            en_cnt   += int'(EN);
            fs_cnt   += int'(flush_sel);
            ov_cnt   += int'(out_valid);
            done_cnt += int'(frame_done);
            err_cnt  += int'(err_sync);
            busy_cnt += int'(busy);
            if (out_valid && first_ov < base_cyc) first_ov = cyc;
            if (frame_done) done_cyc = cyc;
            last_en = EN;
            last_fs = flush_sel;
            cyc++;
        end
    end

    task automatic step(input logic r, input logic pv, input logic s);
        reset = r; pix_valid = pv; sof = s;
        @(posedge clock);
        #1;
    endtask

    int b_en, b_fs, b_ov, b_done, b_err, b_busy;

    task automatic mark();
        base_cyc = cyc;
        b_en = en_cnt; b_fs = fs_cnt; b_ov = ov_cnt;
        b_done = done_cnt; b_err = err_cnt; b_busy = busy_cnt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // 12 back-to-back pixels then the flush, with totals pinned by hand.
    task automatic clean_frame(input string tag);
        mark();
        for (int i = 0; i < WH; i++) step(1'b0, 1'b1, i == 0);
        idle(12);
        check({tag, "_en_cycles"}, en_cnt - b_en, 20);
        check({tag, "_flush_cycles"}, fs_cnt - b_fs, 8);
        check({tag, "_ov_cycles"}, ov_cnt - b_ov, 12);
        check({tag, "_first_ov"}, first_ov - base_cyc, 8);
        check({tag, "_done_count"}, done_cnt - b_done, 1);
        check({tag, "_done_cycle"}, done_cyc - base_cyc, 20);
        check({tag, "_err_count"}, err_cnt - b_err, 0);
    endtask

    initial begin
        reset = 1'b1; pix_valid = 1'b0; sof = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_on = 1'b1;
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_EN", int'(EN), 0);
        check("rst_x_in", int'(x_in), 0);
        step(1'b0, 1'b0, 1'b0);

        // Back-to-back frame.
        clean_frame("s1");

        // Same frame with a gap after every pixel.
        mark();
        for (int i = 0; i < WH; i++) begin
            step(1'b0, 1'b1, i == 0);
            step(1'b0, 1'b0, 1'b0);
        end
        idle(12);
        check("s2_en_cycles", en_cnt - b_en, 20);
        check("s2_flush_cycles", fs_cnt - b_fs, 8);
        check("s2_ov_cycles", ov_cnt - b_ov, 12);
        check("s2_first_ov", first_ov - base_cyc, 15);
        check("s2_done_count", done_cnt - b_done, 1);
        check("s2_done_cycle", done_cyc - base_cyc, 31);

        // Pixels without sof while idle.
        mark();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        check("s3_en_cycles", en_cnt - b_en, 0);
        check("s3_busy_cycles", busy_cnt - b_busy, 0);
        check("s3_x_in", int'(x_in), 0);
        check("s3_y_in", int'(y_in), 0);
        idle(1);

        // sof again on input pixel 6.
        mark();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i == 0);
        step(1'b0, 1'b1, 1'b1);
        check("s4_x_in_after_sof", int'(x_in), 1);
        check("s4_y_in_after_sof", int'(y_in), 0);
        check("s4_err_pulse", int'(err_sync), 1);
        for (int i = 1; i < WH; i++) step(1'b0, 1'b1, 1'b0);
        idle(12);
        check("s4_err_count", err_cnt - b_err, 1);
        check("s4_done_count", done_cnt - b_done, 1);
        check("s4_ov_cycles", ov_cnt - b_ov, 12);
        check("s4_first_ov", first_ov - base_cyc, 14);
        check("s4_en_cycles", en_cnt - b_en, 26);

        // sof during the third flush cycle.
        mark();
        for (int i = 0; i < WH; i++) step(1'b0, 1'b1, i == 0);
        idle(2);
        step(1'b0, 1'b1, 1'b1);
        check("s5_flush_sel_on_sof", int'(last_fs), 0);
        check("s5_EN_on_sof", int'(last_en), 1);
        check("s5_err_pulse", int'(err_sync), 1);
        check("s5_busy", int'(busy), 1);
        for (int i = 1; i < WH; i++) step(1'b0, 1'b1, 1'b0);
        idle(12);
        check("s5_flush_cycles", fs_cnt - b_fs, 10);
        check("s5_done_count", done_cnt - b_done, 1);
        check("s5_err_count", err_cnt - b_err, 1);
        check("s5_ov_cycles", ov_cnt - b_ov, 19);

        // Reset on input pixel 7, then a clean frame.
        mark();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, i == 0);
        step(1'b1, 1'b1, 1'b0);
        reset = 1'b0; pix_valid = 1'b0; sof = 1'b0;
        #1;
        check("s6_busy", int'(busy), 0);
        check("s6_EN", int'(EN), 0);
        check("s6_x_in", int'(x_in), 0);
        check("s6_out_valid", int'(out_valid), 0);
        idle(2);
        check("s6_done_count", done_cnt - b_done, 0);
        check("s6_err_count", err_cnt - b_err, 0);
        clean_frame("s6");

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
